// File: rtl/entrada_botao_responder_if.sv
// Signal bundle between the board pins / CPU IN handshake and the responder.
// slave = responder side, master = CPU/board side.
interface entrada_botao_responder_if #(
  parameter int DATA_W = 4
);
  logic              botaoPlaca;
  logic [DATA_W-1:0] entradaDeDados;
  logic              req;
  logic              botaoIN;
  logic [31:0]       dadoLido;
  logic              ocupado;
  logic [2:0]        estado;

  modport master (
    output botaoPlaca, entradaDeDados, req,
    input  botaoIN, dadoLido, ocupado, estado
  );

  modport slave (
    input  botaoPlaca, entradaDeDados, req,
    output botaoIN, dadoLido, ocupado, estado
  );
endinterface

// File: rtl/entrada_botao_responder.sv
// Debounced push-button responder for the CPU IN handshake: latches the switches and pulses botaoIN.
// Optional macro ENTRADA_ACUMULA_EN: decimal accumulation of presses, ack only on the 4'hF "enter" press.
module entrada_botao_responder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DATA_W          = 4,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input logic                      clk,
  input logic                      reset,
  entrada_botao_responder_if.slave bus
);
  localparam int            CW           = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX      = '1;
  localparam logic          BTN_RELEASED = BTN_ACTIVE_LOW;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WAIT_PRESS   = 3'd1,
    DEBOUNCE     = 3'd2,
    ACK          = 3'd3,
    WAIT_RELEASE = 3'd4
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic              botao_in_q;
  logic              ocupado_q;
  logic [31:0]       dado_q;
  logic              btn_meta_q;
  logic              btn_sync_q;
  logic [DATA_W-1:0] sw_meta_q;
  logic [DATA_W-1:0] sw_sync_q;
  logic              pressed;
  logic [31:0]       sw_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta_q <= BTN_RELEASED;
      btn_sync_q <= BTN_RELEASED;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      btn_meta_q <= bus.botaoPlaca;
      btn_sync_q <= btn_meta_q;
      sw_meta_q  <= bus.entradaDeDados;
      sw_sync_q  <= sw_meta_q;
    end
  end

  // Normalised so that pressed = 1 regardless of board wiring.
  assign pressed = btn_sync_q ^ BTN_RELEASED;
  assign sw_ext  = 32'(sw_sync_q);

`ifdef ENTRADA_ACUMULA_EN
  logic        clr_pend_q;
  logic        is_enter;
  logic [31:0] digit;
  logic [31:0] acc_sum;
  logic [31:0] acc_d;

  assign is_enter = (sw_ext == 32'hF);
  assign digit    = (sw_ext > 32'd9) ? 32'd9 : sw_ext;
  // dado_q never exceeds 999, so x*8 + x*2 cannot overflow.
  assign acc_sum  = {dado_q[28:0], 3'b000} + {dado_q[30:0], 1'b0} + digit;
  assign acc_d    = (acc_sum > 32'd999) ? 32'd999 : acc_sum;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      botao_in_q <= 1'b0;
      ocupado_q  <= 1'b0;
      dado_q     <= '0;
`ifdef ENTRADA_ACUMULA_EN
      clr_pend_q <= 1'b0;
`endif
    end else begin
      botao_in_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // A button already held when the request arrives is ignored until released.
          if (bus.req && !pressed) begin
            state_q   <= WAIT_PRESS;
            ocupado_q <= 1'b1;
            cnt_q     <= '0;
`ifdef ENTRADA_ACUMULA_EN
            if (clr_pend_q) begin
              dado_q     <= '0;
              clr_pend_q <= 1'b0;
            end
`endif
          end
        end
        WAIT_PRESS: begin
          if (!bus.req) begin
            state_q   <= IDLE;
            ocupado_q <= 1'b0;
          end else if (pressed) begin
            state_q <= DEBOUNCE;
            cnt_q   <= '0;
          end
        end
        DEBOUNCE: begin
          if (!bus.req) begin
            state_q   <= IDLE;
            ocupado_q <= 1'b0;
          end else if (!pressed) begin
            state_q <= WAIT_PRESS;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
`ifdef ENTRADA_ACUMULA_EN
            if (is_enter) begin
              state_q    <= ACK;
              botao_in_q <= 1'b1;
              clr_pend_q <= 1'b1;
            end else begin
              dado_q  <= acc_d;
              state_q <= WAIT_RELEASE;
              cnt_q   <= '0;
            end
`else
            dado_q     <= sw_ext;
            state_q    <= ACK;
            botao_in_q <= 1'b1;
`endif
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ACK: begin
          state_q <= WAIT_RELEASE;
          cnt_q   <= '0;
        end
        WAIT_RELEASE: begin
          if (pressed) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= IDLE;
            ocupado_q <= 1'b0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          ocupado_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.botaoIN  = botao_in_q;
  assign bus.dadoLido = dado_q;
  assign bus.ocupado  = ocupado_q;
  assign bus.estado   = state_q;
endmodule

// File: tb/tb_entrada_botao_responder.sv
// Bench for entrada_botao_responder: per-cycle comparison against a run-length reference model,
// directed scenarios with hand-computed expectations, then randomized stimulus.
module tb_entrada_botao_responder;
  localparam int D = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   ack_seen = 0;

  entrada_botao_responder_if #(.DATA_W(4)) bus ();

  entrada_botao_responder #(
    .DEBOUNCE_CYCLES(D),
    .DATA_W(4),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: synced button seen through a 2-deep sample history, progress tracked
  // as run lengths of consecutive pressed / released samples.
  bit         btn_pipe [2];
  int         sw_pipe  [2];
  bit         m_busy, m_ack, m_rel, m_clr;
  int         m_hold, m_relrun, m_dado;

  task automatic model_reset();
    btn_pipe[0] = 1'b1; btn_pipe[1] = 1'b1;
    sw_pipe[0] = 0; sw_pipe[1] = 0;
    m_busy = 0; m_ack = 0; m_rel = 0; m_clr = 0;
    m_hold = 0; m_relrun = 0; m_dado = 0;
  endtask

  task automatic accept(input int swv);
`ifdef ENTRADA_ACUMULA_EN
    if (swv == 15) begin
      m_ack = 1; m_clr = 1;
    end else begin
      m_dado = m_dado * 10 + ((swv > 9) ? 9 : swv);
      if (m_dado > 999) m_dado = 999;
      m_rel = 1; m_relrun = 0;
    end
`else
    m_dado = swv;
    m_ack  = 1;
`endif
  endtask

  task automatic model_step();
    bit pr;
    int swv;
    pr  = (btn_pipe[1] == 1'b0);
    swv = sw_pipe[1];
    if (m_ack) begin
      m_ack = 0; m_rel = 1; m_relrun = 0;
    end else if (m_rel) begin
      if (pr) m_relrun = 0;
      else begin
        m_relrun++;
        if (m_relrun == D) begin m_rel = 0; m_busy = 0; end
      end
    end else if (m_busy) begin
      if (!bus.req) begin m_busy = 0; m_hold = 0; end
      else if (!pr) m_hold = 0;
      else begin
        m_hold++;
        if (m_hold == D + 1) begin m_hold = 0; accept(swv); end
      end
    end else if (bus.req && !pr) begin
      m_busy = 1; m_hold = 0;
      if (m_clr) begin m_dado = 0; m_clr = 0; end
    end
    btn_pipe[1] = btn_pipe[0]; btn_pipe[0] = bus.botaoPlaca;
    sw_pipe[1]  = sw_pipe[0];  sw_pipe[0]  = int'(bus.entradaDeDados);
  endtask

  function automatic int exp_estado();
    if (m_ack) return 3;
    if (m_rel) return 4;
    if (!m_busy) return 0;
    return (m_hold == 0) ? 1 : 2;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
      #1;
      chk("botaoIN", 32'(bus.botaoIN), 32'(m_ack));
      chk("dadoLido", bus.dadoLido, 32'(m_dado));
      chk("ocupado", 32'(bus.ocupado), 32'(m_busy));
      chk("estado", 32'(bus.estado), 32'(exp_estado()));
      if (bus.botaoIN) ack_seen++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic btn(input bit press);
    bus.botaoPlaca = ~press;
  endtask

  task automatic wait_ack(output bit seen);
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); #1;
      if (bus.botaoIN) seen = 1;
    end
    chk("ack_timeout", 32'(seen), 32'd1);
  endtask

`ifdef ENTRADA_ACUMULA_EN
  task automatic press_digit(input logic [3:0] d);
    @(negedge clk); bus.entradaDeDados = d; btn(1);
    cycles(20); btn(0); cycles(20);
  endtask
`endif

  initial begin
    int base, lat;
    bit seen;
    logic [3:0] ack_sw;
    bus.botaoPlaca = 1'b1; bus.entradaDeDados = 4'h0; bus.req = 1'b0;
`ifdef ENTRADA_ACUMULA_EN
    ack_sw = 4'hF;
`else
    ack_sw = 4'h6;
`endif
    cycles(3);
    chk("rst_estado", 32'(bus.estado), 32'd0);
    chk("rst_dado", bus.dadoLido, 32'd0);
    chk("rst_ack", 32'(bus.botaoIN), 32'd0);
    chk("rst_ocupado", 32'(bus.ocupado), 32'd0);
    reset = 1'b0;
    cycles(2);

`ifndef ENTRADA_ACUMULA_EN
    // Basic read: ack 2+16+1 edges after the raw press, idle 2+16 edges after release.
    base = ack_seen;
    bus.req = 1; cycles(3);
    bus.entradaDeDados = 4'h5; btn(1);
    lat = 0; seen = 0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1; lat++;
      if (bus.botaoIN) seen = 1;
    end
    chk("basic_latency", 32'(lat), 32'd19);
    chk("basic_dado", bus.dadoLido, 32'd5);
    cycles(11); btn(0);
    lat = 0; seen = 0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1; lat++;
      if (!bus.ocupado) seen = 1;
    end
    chk("basic_release_latency", 32'(lat), 32'd18);
    chk("basic_acks", 32'(ack_seen - base), 32'd1);
    @(negedge clk); bus.req = 0; cycles(3);

    // Glitch rejection.
    base = ack_seen;
    bus.req = 1; bus.entradaDeDados = 4'h0; cycles(3);
    btn(1); cycles(10); btn(0); cycles(4);
    bus.entradaDeDados = 4'hA; btn(1); cycles(20); btn(0); cycles(20);
    chk("glitch_acks", 32'(ack_seen - base), 32'd1);
    chk("glitch_dado", bus.dadoLido, 32'd10);
    bus.req = 0; cycles(3);

    // Stale press.
    base = ack_seen;
    btn(1); cycles(5); bus.req = 1; cycles(25);
    chk("stale_idle", 32'(bus.estado), 32'd0);
    chk("stale_acks", 32'(ack_seen - base), 32'd0);
    btn(0); cycles(16);
    bus.entradaDeDados = 4'h3; btn(1); cycles(22); btn(0); cycles(20);
    chk("stale_acks2", 32'(ack_seen - base), 32'd1);
    chk("stale_dado", bus.dadoLido, 32'd3);
    bus.req = 0; cycles(3);

    // Abort at debounce count 8.
    base = ack_seen;
    bus.req = 1; bus.entradaDeDados = 4'h7; cycles(3);
    btn(1); cycles(11); bus.req = 0; cycles(3);
    chk("abort_idle", 32'(bus.estado), 32'd0);
    chk("abort_acks", 32'(ack_seen - base), 32'd0);
    chk("abort_dado", bus.dadoLido, 32'd3);
    btn(0); cycles(20);
`else
    base = ack_seen;
    bus.req = 1; cycles(3);
    press_digit(4'h1); press_digit(4'h2); press_digit(4'h3);
    chk("acc_no_ack", 32'(ack_seen - base), 32'd0);
    press_digit(4'hF);
    chk("acc_acks", 32'(ack_seen - base), 32'd1);
    chk("acc_123", bus.dadoLido, 32'd123);
    press_digit(4'h9); press_digit(4'h9); press_digit(4'h9); press_digit(4'h9);
    press_digit(4'hF);
    chk("acc_acks2", 32'(ack_seen - base), 32'd2);
    chk("acc_999", bus.dadoLido, 32'd999);
    bus.req = 0; cycles(20);
`endif

    // Asynchronous reset while debouncing.
    bus.req = 1; bus.entradaDeDados = ack_sw; cycles(3);
    btn(1); cycles(8);
    #2 reset = 1'b1; #1;
    chk("rstdb_estado", 32'(bus.estado), 32'd0);
    chk("rstdb_ocupado", 32'(bus.ocupado), 32'd0);
    chk("rstdb_dado", bus.dadoLido, 32'd0);
    @(negedge clk); btn(0); bus.req = 0;
    @(negedge clk); reset = 1'b0; cycles(3);

    // Asynchronous reset during the ack cycle.
    bus.req = 1; cycles(3); btn(1);
    wait_ack(seen);
    #2 reset = 1'b1; #1;
    chk("rstack_ack", 32'(bus.botaoIN), 32'd0);
    chk("rstack_estado", 32'(bus.estado), 32'd0);
    @(negedge clk); btn(0); bus.req = 0;
    @(negedge clk); reset = 1'b0;
    base = ack_seen;
    cycles(30);
    chk("rstack_no_ack", 32'(ack_seen - base), 32'd0);

    // Randomized segments.
    for (int s = 0; s < 150; s++) begin
      @(negedge clk);
      if ($urandom_range(0, 40) == 0) begin
        reset = 1'b1; @(negedge clk); reset = 1'b0;
      end
      bus.req = ($urandom_range(0, 3) != 0);
      btn(1'($urandom_range(0, 1)));
      bus.entradaDeDados = 4'($urandom_range(0, 15));
      cycles($urandom_range(1, 40));
    end
    bus.req = 0; btn(0); cycles(25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
